// File: rtl/onchip_arb_pkg.sv
// Shared types and default widths for the on-chip memory arbiter.
// The arbiter top honours the optional MEMARB_LOCK_EN build macro.
package onchip_arb_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    // Index of the granted master (0 = m0, 1 = m1)
    typedef logic grant_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin grant with an optional exclusive hold
// for the previous winner (lock).
module rr_arbiter_2
    import onchip_arb_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    input  logic       lock,
    output grant_t     grant,
    output logic       grant_vld
);

    always_comb begin
        grant     = last_grant;
        grant_vld = 1'b0;
        if (lock) begin
            // Locked owner is the previous winner; the other master is stalled
            grant     = last_grant;
            grant_vld = req[last_grant];
        end else begin
            grant_vld = |req;
            case (req)
                2'b01:   grant = 1'b0;
                2'b10:   grant = 1'b1;
                2'b11:   grant = ~last_grant;
                default: grant = last_grant;
            endcase
        end
    end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port, 1-cycle-latency RAM.
// Define MEMARB_LOCK_EN to add mN_lock inputs for exclusive back-to-back access.
module onchip_memory_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
`ifdef MEMARB_LOCK_EN
    input  logic                  m0_lock,
    input  logic                  m1_lock,
`endif
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    state_t              state, state_nx;
    grant_t              grant, last_grant, arb_grant;
    logic                arb_vld, arb_lock, rd;
    logic                win_read, win_write;
    logic [DATA_W-1:0]   rd_hold0, rd_hold1;

`ifdef MEMARB_LOCK_EN
    logic                lock_q;
    assign arb_lock = lock_q;
`else
    assign arb_lock = 1'b0;
`endif

    assign mem_clken = 1'b1;

    rr_arbiter_2 u_arb (
        .req        ({m1_read | m1_write, m0_read | m0_write}),
        .last_grant (last_grant),
        .lock       (arb_lock),
        .grant      (arb_grant),
        .grant_vld  (arb_vld)
    );

    assign win_read  = arb_grant ? m1_read  : m0_read;
    assign win_write = arb_grant ? m1_write : m0_write;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            grant          <= 1'b0;
            rd             <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            rd_hold0       <= '0;
            rd_hold1       <= '0;
`ifdef MEMARB_LOCK_EN
            lock_q         <= 1'b0;
`endif
        end else begin
            state          <= state_nx;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            case (state)
                IDLE: if (arb_vld) begin
                    grant          <= arb_grant;
                    // A simultaneous read+write is treated as a write
                    rd             <= win_read & ~win_write;
                    mem_address    <= arb_grant ? m1_address    : m0_address;
                    mem_byteenable <= arb_grant ? m1_byteenable : m0_byteenable;
                    mem_writedata  <= arb_grant ? m1_writedata  : m0_writedata;
                    mem_chipselect <= 1'b1;
                    mem_write      <= win_write;
                end
                ISSUE: begin
                    last_grant <= grant;
`ifdef MEMARB_LOCK_EN
                    lock_q     <= grant ? m1_lock : m0_lock;
`endif
                end
                RESP: begin
                    if (grant) rd_hold1 <= mem_readdata;
                    else       rd_hold0 <= mem_readdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx         = state;
        m0_waitrequest   = 1'b1;
        m1_waitrequest   = 1'b1;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        m0_readdata      = rd_hold0;
        m1_readdata      = rd_hold1;
        case (state)
            IDLE: if (arb_vld) state_nx = ISSUE;
            ISSUE: begin
                state_nx = rd ? RESP : IDLE;
                if (grant) m1_waitrequest = 1'b0;
                else       m0_waitrequest = 1'b0;
            end
            RESP: begin
                state_nx = IDLE;
                // RAM q is unregistered: pass it straight through in the response cycle
                if (grant) begin
                    m1_readdatavalid = 1'b1;
                    m1_readdata      = mem_readdata;
                end else begin
                    m0_readdatavalid = 1'b1;
                    m0_readdata      = mem_readdata;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Self-checking bench for onchip_memory_arbiter: RAM model, per-master bus tasks,
// scoreboard memory and arbitration-order checks (lock scenario under MEMARB_LOCK_EN).
module tb_onchip_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] m_addr  [2];
    logic [3:0]  m_be    [2];
    logic        m_read  [2];
    logic        m_write [2];
    logic [31:0] m_wdata [2];
    logic        m_wait  [2];
    logic        m_rdv   [2];
    logic [31:0] m_rdata [2];
`ifdef MEMARB_LOCK_EN
    logic        m_lock  [2];
`endif
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_q;

    logic [31:0] ram   [0:8191];
    logic [31:0] model [0:8191];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int viol = 0;
    int acc_cnt [2];
    int order_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    onchip_memory_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m_addr[0]),
        .m0_byteenable    (m_be[0]),
        .m0_read          (m_read[0]),
        .m0_write         (m_write[0]),
        .m0_writedata     (m_wdata[0]),
        .m0_waitrequest   (m_wait[0]),
        .m0_readdata      (m_rdata[0]),
        .m0_readdatavalid (m_rdv[0]),
        .m1_address       (m_addr[1]),
        .m1_byteenable    (m_be[1]),
        .m1_read          (m_read[1]),
        .m1_write         (m_write[1]),
        .m1_writedata     (m_wdata[1]),
        .m1_waitrequest   (m_wait[1]),
        .m1_readdata      (m_rdata[1]),
        .m1_readdatavalid (m_rdv[1]),
`ifdef MEMARB_LOCK_EN
        .m0_lock          (m_lock[0]),
        .m1_lock          (m_lock[1]),
`endif
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_q)
    );

    // Single-port RAM: address/data registered at the edge, q valid the next cycle
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_q <= ram[mem_address];
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (m_rdv[0] && m_rdv[1]) viol++;
            if (!m_wait[0] && !m_wait[1]) viol++;
            if (mem_write && !mem_chipselect) viol++;
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One bus transaction from master id; starts and returns 1 time unit after a posedge.
    task automatic access(input int id, input bit wr, input bit rd, input logic [12:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          output int lat_acc, output int lat_rdv, output logic [31:0] rdata);
        int c0, snap, n;
        bit done;
        logic [31:0] exp;
        m_addr[id] = addr; m_be[id] = be; m_wdata[id] = data;
        m_read[id] = rd; m_write[id] = wr;
        c0 = cyc; snap = acc_cnt[1-id]; n = 0; done = 1'b0;
        lat_acc = -1; lat_rdv = -1; rdata = '0; exp = '0;
        while (!done && n < 60) begin
            @(negedge clk);
            if (m_wait[id] === 1'b0) begin
                lat_acc = cyc - c0;
                @(posedge clk);
                acc_cnt[id]++;
                order_q.push_back(id);
                if (wr) model[addr] = merge(model[addr], data, be);
                else    exp = model[addr];
                done = 1'b1;
            end else begin
                @(posedge clk);
            end
            n++;
        end
        #1;
        m_read[id] = 1'b0; m_write[id] = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL accept_timeout m%0d: waitrequest stayed %b, required 0", id, m_wait[id]);
            return;
        end
        checks++;
        if (acc_cnt[1-id] - snap > 1) begin
            failures++;
            $display("FAIL starvation m%0d: other master served %0d times, required <=1", id, acc_cnt[1-id] - snap);
        end
        if (rd && !wr) begin
            @(negedge clk);
            lat_rdv = cyc - c0;
            rdata = m_rdata[id];
            checks++;
            if (m_rdv[id] !== 1'b1 || rdata !== exp) begin
                failures++;
                $display("FAIL read_data m%0d @%h: rdv=%b data=%h, required rdv=1 data=%h", id, addr, m_rdv[id], rdata, exp);
            end
            @(posedge clk);
            #1;
        end else if (rd && wr) begin
            @(negedge clk);
            checks++;
            if (m_rdv[id] !== 1'b0) begin
                failures++;
                $display("FAIL rw_conflict_rdv m%0d: rdv=%b, required 0", id, m_rdv[id]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_wait[0], m_wait[1], m_rdv[0], m_rdv[1], mem_chipselect, mem_write, mem_clken} !== 7'b1100001) begin
            failures++;
            $display("FAIL reset_ctrl: wait/rdv/cs/we/clken=%b, required 1100001",
                     {m_wait[0], m_wait[1], m_rdv[0], m_rdv[1], mem_chipselect, mem_write, mem_clken});
        end
        checks++;
        if ({m_rdata[0], m_rdata[1]} !== 64'h0) begin
            failures++;
            $display("FAIL reset_readdata: %h %h, required 0 0", m_rdata[0], m_rdata[1]);
        end
        checks++;
        if ({mem_address, mem_byteenable, mem_writedata} !== 49'h0) begin
            failures++;
            $display("FAIL reset_mem_regs: addr=%h be=%h wd=%h, required 0", mem_address, mem_byteenable, mem_writedata);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        int la, lr;
        logic [31:0] rd;
        access(0, 1'b1, 1'b0, 13'h0010, 32'hDEADBEEF, 4'hF, la, lr, rd);
        checks++;
        if (la !== 1) begin failures++; $display("FAIL wr_latency: %0d, required 1", la); end
        access(0, 1'b0, 1'b1, 13'h0010, 32'h0, 4'h0, la, lr, rd);
        checks++;
        if (la !== 1 || lr !== 2) begin failures++; $display("FAIL rd_latency: accept=%0d rdv=%0d, required 1 2", la, lr); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_value: %h, required deadbeef", rd); end
    endtask

    task automatic test_both_read();
        int la0, lr0, la1, lr1, la, lr;
        logic [31:0] rd0, rd1, rd;
        access(1, 1'b1, 1'b0, 13'h0021, 32'h5A5A1234, 4'hF, la, lr, rd);
        apply_reset();
        fork
            access(0, 1'b0, 1'b1, 13'h0010, 32'h0, 4'h0, la0, lr0, rd0);
            access(1, 1'b0, 1'b1, 13'h0021, 32'h0, 4'h0, la1, lr1, rd1);
        join
        checks++;
        if (la0 !== 1 || lr0 !== 2) begin failures++; $display("FAIL both_rd_m0_latency: %0d %0d, required 1 2", la0, lr0); end
        checks++;
        if (la1 !== 4 || lr1 !== 5) begin failures++; $display("FAIL both_rd_m1_latency: %0d %0d, required 4 5", la1, lr1); end
        checks++;
        if (rd0 !== 32'hDEADBEEF || rd1 !== 32'h5A5A1234) begin
            failures++; $display("FAIL both_rd_data: %h %h, required deadbeef 5a5a1234", rd0, rd1);
        end
        @(negedge clk);
        checks++;
        if (m_rdata[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL readdata_hold m0: %h, required deadbeef", m_rdata[0]); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        order_q.delete();
        fork
            for (int i = 0; i < 8; i++) begin
                int la, lr; logic [31:0] rd;
                access(0, 1'b1, 1'b0, 13'h0100 + 13'(i), $urandom, 4'hF, la, lr, rd);
            end
            for (int j = 0; j < 8; j++) begin
                int la, lr; logic [31:0] rd;
                access(1, 1'b1, 1'b0, 13'h0200 + 13'(j), $urandom, 4'hF, la, lr, rd);
            end
        join
        checks++;
        if (order_q.size() !== 16) begin failures++; $display("FAIL b2b_count: %0d, required 16", order_q.size()); end
        for (int k = 1; k < order_q.size(); k++) begin
            checks++;
            if (order_q[k] === order_q[k-1]) begin
                failures++; $display("FAIL b2b_alternate[%0d]: m%0d twice in a row", k, order_q[k]);
            end
        end
    endtask

    task automatic test_byte_lane();
        int la, lr;
        logic [31:0] rd;
        access(1, 1'b1, 1'b0, 13'h1FFF, 32'hFFFFFFFF, 4'hF, la, lr, rd);
        access(1, 1'b1, 1'b0, 13'h1FFF, 32'h0000AB00, 4'b0010, la, lr, rd);
        access(1, 1'b0, 1'b1, 13'h1FFF, 32'h0, 4'h0, la, lr, rd);
        checks++;
        if (rd !== 32'hFFFFABFF) begin failures++; $display("FAIL byte_lane: %h, required ffffabff", rd); end
    endtask

    task automatic test_rw_conflict();
        int la, lr;
        logic [31:0] rd;
        access(0, 1'b1, 1'b1, 13'h0030, 32'h13572468, 4'hF, la, lr, rd);
        checks++;
        if (la !== 1) begin failures++; $display("FAIL rw_conflict_latency: %0d, required 1", la); end
        access(0, 1'b0, 1'b1, 13'h0030, 32'h0, 4'h0, la, lr, rd);
        checks++;
        if (rd !== 32'h13572468) begin failures++; $display("FAIL rw_conflict_data: %h, required 13572468", rd); end
    endtask

    task automatic test_reset_resp();
        int n, la, lr;
        bit ok;
        logic [31:0] rd;
        m_addr[0] = 13'h0010; m_read[0] = 1'b1; ok = 1'b0; n = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (m_wait[0] === 1'b0) ok = 1'b1;
            @(posedge clk);
            n++;
        end
        #1;
        m_read[0] = 1'b0;
        reset_n = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL rst_resp_accept: waitrequest=%b, required 0", m_wait[0]); end
        @(negedge clk);
        checks++;
        if (m_rdv[0] !== 1'b1) begin failures++; $display("FAIL rst_resp_before: rdv=%b, required 1", m_rdv[0]); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_rdv[0], m_rdv[1], m_wait[0], m_wait[1]} !== 4'b0011 || m_rdata[0] !== 32'h0) begin
            failures++;
            $display("FAIL rst_resp_after: rdv=%b%b wait=%b%b rdata=%h, required 00 11 0",
                     m_rdv[0], m_rdv[1], m_wait[0], m_wait[1], m_rdata[0]);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        access(0, 1'b0, 1'b1, 13'h0010, 32'h0, 4'h0, la, lr, rd);
        checks++;
        if (la !== 1 || lr !== 2) begin failures++; $display("FAIL rst_resp_idle: %0d %0d, required 1 2", la, lr); end
    endtask

    task automatic test_random();
        int la, lr;
        logic [31:0] rd;
        for (int a = 0; a < 16; a++) access(0, 1'b1, 1'b0, 13'h0040 + 13'(a), $urandom, 4'hF, la, lr, rd);
        fork
            for (int i = 0; i < 25; i++) begin
                int l0, r0, g0; logic [31:0] d0; bit isrd0;
                g0 = $urandom_range(0, 2);
                if (g0 > 0) begin repeat (g0) @(posedge clk); #1; end
                isrd0 = ($urandom_range(0, 2) == 0);
                access(0, !isrd0, isrd0, 13'h0040 + 13'($urandom_range(0, 15)), $urandom,
                       4'($urandom_range(1, 15)), l0, r0, d0);
                if (isrd0) begin
                    checks++;
                    if (r0 !== l0 + 1) begin failures++; $display("FAIL rand_rdv_latency m0: %0d, required %0d", r0, l0 + 1); end
                end
            end
            for (int j = 0; j < 25; j++) begin
                int l1, r1, g1; logic [31:0] d1; bit isrd1;
                g1 = $urandom_range(0, 2);
                if (g1 > 0) begin repeat (g1) @(posedge clk); #1; end
                isrd1 = ($urandom_range(0, 2) == 0);
                access(1, !isrd1, isrd1, 13'h0040 + 13'($urandom_range(0, 15)), $urandom,
                       4'($urandom_range(1, 15)), l1, r1, d1);
                if (isrd1) begin
                    checks++;
                    if (r1 !== l1 + 1) begin failures++; $display("FAIL rand_rdv_latency m1: %0d, required %0d", r1, l1 + 1); end
                end
            end
        join
    endtask

`ifdef MEMARB_LOCK_EN
    task automatic test_lock();
        int la1, lr1;
        logic [31:0] rd1;
        apply_reset();
        order_q.delete();
        fork
            for (int i = 0; i < 4; i++) begin
                int la, lr; logic [31:0] rd;
                m_lock[0] = (i < 3);
                access(0, 1'b1, 1'b0, 13'h0300 + 13'(i), $urandom, 4'hF, la, lr, rd);
            end
            access(1, 1'b1, 1'b0, 13'h0310, 32'hCAFEF00D, 4'hF, la1, lr1, rd1);
        join
        m_lock[0] = 1'b0;
        checks++;
        if (la1 !== 9) begin failures++; $display("FAIL lock_m1_latency: %0d, required 9", la1); end
        checks++;
        if (order_q.size() !== 5 || order_q[4] !== 1 || order_q[0] !== 0 || order_q[3] !== 0) begin
            failures++; $display("FAIL lock_order: size=%0d last=m%0d, required 5 and m1 last", order_q.size(), order_q[order_q.size()-1]);
        end
    endtask
`endif

    task automatic test_invariants();
        checks++;
        if (viol !== 0) begin failures++; $display("FAIL invariants: %0d violations, required 0", viol); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0; m_be[i] = '0; m_read[i] = 1'b0; m_write[i] = 1'b0; m_wdata[i] = '0;
            acc_cnt[i] = 0;
`ifdef MEMARB_LOCK_EN
            m_lock[i] = 1'b0;
`endif
        end
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_both_read();
        test_back_to_back();
        test_byte_lane();
        test_rw_conflict();
        test_reset_resp();
        test_random();
`ifdef MEMARB_LOCK_EN
        test_lock();
`endif
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
